uart_core_cfg: RTL and testbench
================================

Name: uart_core_cfg

Overview:
- Parametrised full-duplex UART core; next generation of the fixed 8N1 transmitter/receiver pair.
- Adds configurable data width, parity mode, stop-bit count and bit period.
- Adds mid-bit RX sampling with false-start rejection, parity/framing error reporting, and an internal loopback mode.
- Sits between the host-side byte interface (newd/dintx/donetx, doutrx/donerx) and the serial pins.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits transmitted; 1 or 2.
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- loopback  in  1  1 = RX input is the internal TX output; rx pin ignored.
- newd  in  1  TX request; sampled each cycle.
- dintx  in  DATA_BITS  TX data; captured when newd is accepted.
- tx  out  1  serial output; idles high.
- txbusy  out  1  high from acceptance until the end of the last stop bit.
- donetx  out  1  one-cycle pulse when the frame completes.
- rx  in  1  serial input; asynchronous to clk.
- doutrx  out  DATA_BITS  last received data; held until the next frame completes.
- donerx  out  1  one-cycle pulse when a frame is received.
- perr  out  1  parity error of the last frame; updated with donerx.
- ferr  out  1  framing error of the last frame; updated with donerx.

Behaviour:
- Reset values (rst low, asynchronous): tx = 1; txbusy, donetx, donerx, perr, ferr = 0; doutrx = 0.
- Reset values (continued): both FSMs in IDLE; all counters and the synchroniser = 1s/0s as idle-high requires.
- Reset mid-frame aborts immediately: tx returns high in the same edge as reset assertion.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles. Default 8N1 = 160 cycles.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE.
- TX accept: newd = 1 in IDLE latches dintx and sets txbusy on the same edge. tx drives the start bit (0) from the next cycle.
- TX timing: each bit is held exactly CLKS_PER_BIT cycles.
- TX parity bit: XOR of the data bits for even; inverted XOR for odd.
- TX STOP: drives 1 for STOP_BITS * CLKS_PER_BIT cycles. donetx pulses in the final cycle of the stop period. txbusy falls on the same edge that the FSM returns to IDLE.
- TX: newd while txbusy = 1 is ignored. No queueing. dintx changes after acceptance have no effect.
- Back-to-back TX: newd asserted in the first IDLE cycle starts the next start bit with no idle gap beyond one cycle.
- RX synchroniser: rx passes through a 2-flop synchroniser (reset value 1). The loopback mux sits after the synchroniser; the loopback path bypasses it.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
- RX IDLE: a low on the synchronised line enters START.
- RX START: waits CLKS_PER_BIT/2 cycles and re-samples. If high, the start is rejected as a glitch and the FSM returns to IDLE with no donerx.
- RX DATA/PARITY: samples every CLKS_PER_BIT cycles after the mid-start point, i.e. mid-bit. Data is shifted in LSB first.
- RX STOP: samples only the first stop bit.
  - Sample 0 -> ferr = 1; the FSM then waits until the line is high before re-arming (break handling).
  - Sample 1 -> ferr = 0.
- RX completion: donerx pulses one cycle after the stop sample. doutrx, perr and ferr update on the same edge as the donerx pulse.
- perr is 0 when PARITY = 0. A frame with errors still updates doutrx and pulses donerx.
- TX and RX operate independently and simultaneously. In loopback, donerx for a frame arrives in the middle of its stop bit, before donetx.

Test Plan:
- Reset, loopback = 1, defaults: send 0x00, 0xFF, 0xAA, 0x55 back-to-back -> each doutrx matches, perr = ferr = 0. Each frame = 160 cycles; tx is 0 for exactly 16 cycles of start bit.
- DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, loopback = 1: send 0x5A -> tx bit sequence 0,0,1,0,1,1,0,1,0,1,1 (start, LSB-first data, parity = 0, two stops); doutrx = 0x5A, perr = 0.
- PARITY = 2, loopback = 0, bench drives rx with 0x3C and a wrong parity bit -> donerx pulses, doutrx = 0x3C, perr = 1, ferr = 0. The next good frame clears perr.
- loopback = 0, rx driven with the stop bit held 0 then line low 100 cycles -> ferr = 1 with donerx. No new frame is detected until rx returns high; the subsequent 0xC3 frame decodes with ferr = 0.
- rx low pulse of CLKS_PER_BIT/4 cycles -> no donerx. A valid frame 20 cycles later decodes correctly.
- newd held high during an active frame -> only one frame sent, one donetx. Assert rst low mid-frame -> tx = 1, txbusy = 0 immediately, no donetx/donerx after release.

Source files
------------

// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART: parametrised data width, parity, stop bits and bit period,
// with mid-bit RX sampling, false-start rejection, parity/framing errors and internal loopback.
module uart_core_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loopback,
    input  logic                 newd,
    input  logic [DATA_BITS-1:0] dintx,
    output logic                 tx,
    output logic                 txbusy,
    output logic                 donetx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donerx,
    output logic                 perr,
    output logic                 ferr
);

    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CW        = $clog2(STOP_CLKS + 1);
    localparam int BW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit ODD        = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
    } state_t;

    state_t                 tx_state, tx_state_nx;
    logic [CW-1:0]          tx_cnt;
    logic [BW-1:0]          tx_idx;
    logic [DATA_BITS-1:0]   tx_shreg;
    logic                   tx_par;
    logic                   tx_bit_end;

    // TX outputs are decoded from registered state so reset forces the line high at once
    always_comb begin
        tx_state_nx = tx_state;
        tx          = 1'b1;
        txbusy      = 1'b1;
        donetx      = 1'b0;
        tx_bit_end  = (tx_cnt == BIT_LAST);
        case (tx_state)
            S_IDLE: begin
                txbusy = 1'b0;
                if (newd) tx_state_nx = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_state_nx = S_DATA;
            end
            S_DATA: begin
                tx = tx_shreg[0];
                if (tx_bit_end && tx_idx == DATA_LAST)
                    tx_state_nx = HAS_PARITY ? S_PAR : S_STOP;
            end
            S_PAR: begin
                tx = tx_par;
                if (tx_bit_end) tx_state_nx = S_STOP;
            end
            S_STOP: begin
                tx_bit_end = (tx_cnt == STOP_LAST);
                if (tx_bit_end) begin
                    donetx      = 1'b1;
                    tx_state_nx = S_IDLE;
                end
            end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            if (tx_state == S_IDLE) begin
                tx_cnt <= '0;
                tx_idx <= '0;
                if (newd) begin
                    tx_shreg <= dintx;
                    tx_par   <= (^dintx) ^ ODD;
                end
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == S_DATA) begin
                    tx_shreg <= tx_shreg >> 1;
                    tx_idx   <= tx_idx + BW'(1);
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    logic [1:0]             rx_sync;
    logic                   rx_line;
    state_t                 rx_state, rx_state_nx;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_idx;
    logic [DATA_BITS-1:0]   rx_shreg;
    logic                   rx_par;
    logic                   rx_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], rx};
    end

    // Loopback taps the TX line directly, so it skips the synchroniser delay
    assign rx_line = loopback ? tx : rx_sync[1];

    always_comb begin
        rx_state_nx = rx_state;
        rx_sample   = 1'b0;
        case (rx_state)
            S_IDLE: if (!rx_line) rx_state_nx = S_START;
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_sample   = 1'b1;
                    rx_state_nx = rx_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_sample = 1'b1;
                    if (rx_idx == DATA_LAST)
                        rx_state_nx = HAS_PARITY ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_sample   = 1'b1;
                    rx_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_sample   = 1'b1;
                    rx_state_nx = rx_line ? S_IDLE : S_BRK;
                end
            end
            S_BRK: if (rx_line) rx_state_nx = S_IDLE;
            default: rx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
            rx_par   <= 1'b0;
            doutrx   <= '0;
            donerx   <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            donerx   <= 1'b0;
            if (rx_state == S_IDLE || rx_state == S_BRK) begin
                rx_cnt <= '0;
                rx_idx <= '0;
            end else if (rx_sample) begin
                rx_cnt <= '0;
                case (rx_state)
                    S_DATA: begin
                        rx_shreg <= {rx_line, rx_shreg[DATA_BITS-1:1]};
                        rx_idx   <= rx_idx + BW'(1);
                    end
                    S_PAR: rx_par <= rx_line;
                    S_STOP: begin
                        donerx <= 1'b1;
                        doutrx <= rx_shreg;
                        perr   <= HAS_PARITY && ((^rx_shreg ^ rx_par) != ODD);
                        ferr   <= ~rx_line;
                    end
                    default: ;
                endcase
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Scoreboard bench for uart_core_cfg: three instances (8N1, 7E2, 8O1) share clock and reset;
// stimulus pushes expected RX results, per-instance monitors pop them on donerx.
module tb_uart_core_cfg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    logic       loop0 = 1'b0, newd0 = 1'b0, rx0 = 1'b1;
    logic [7:0] din0 = '0, dout0;
    logic       tx0, busy0, dtx0, drx0, perr0, ferr0;

    logic       newd1 = 1'b0, rx1 = 1'b1, loop1 = 1'b1;
    logic [6:0] din1 = '0, dout1;
    logic       tx1, busy1, dtx1, drx1, perr1, ferr1;

    logic       newd2 = 1'b0, rx2 = 1'b1, loop2 = 1'b0;
    logic [7:0] din2 = '0, dout2;
    logic       tx2, busy2, dtx2, drx2, perr2, ferr2;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    uart_core_cfg dut0 (
        .clk(clk), .rst(rst), .loopback(loop0), .newd(newd0), .dintx(din0),
        .tx(tx0), .txbusy(busy0), .donetx(dtx0), .rx(rx0), .doutrx(dout0),
        .donerx(drx0), .perr(perr0), .ferr(ferr0)
    );

    uart_core_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .loopback(loop1), .newd(newd1), .dintx(din1),
        .tx(tx1), .txbusy(busy1), .donetx(dtx1), .rx(rx1), .doutrx(dout1),
        .donerx(drx1), .perr(perr1), .ferr(ferr1)
    );

    uart_core_cfg #(.PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .loopback(loop2), .newd(newd2), .dintx(din2),
        .tx(tx2), .txbusy(busy2), .donetx(dtx2), .rx(rx2), .doutrx(dout2),
        .donerx(drx2), .perr(perr2), .ferr(ferr2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives n serial bits (LSB first, 16 clocks each) onto rx of dut0 or dut2
    task automatic applyStimulus(input int dutSel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (dutSel == 0) rx0 = bits[i];
            else             rx2 = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic sendTx0(input logic [7:0] d, input bit hold, input bit expectRx);
        logic [9:0] fb;
        int waveErr, busyErr, doneErr;
        fb = {1'b1, d, 1'b0};
        waveErr = 0; busyErr = 0; doneErr = 0;
        if (expectRx) q0.push_back({1'b0, d, 2'b00});
        din0 = d;
        newd0 = 1'b1;
        @(posedge clk);
        #1;
        din0 = ~d;
        if (!hold) newd0 = 1'b0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (tx0 !== fb[k/16]) waveErr++;
            if (busy0 !== 1'b1) busyErr++;
            if (dtx0 !== (k == 159)) doneErr++;
            if (hold && k == 100) newd0 = 1'b0;
        end
        checkOutput("tx_wave", waveErr, 0);
        checkOutput("txbusy_len", busyErr, 0);
        checkOutput("donetx_pos", doneErr, 0);
        @(negedge clk);
        checkOutput("txbusy_fall", busy0, 0);
    endtask

    always @(negedge clk) begin
        if (rst && drx0) begin
            if (q0.size() == 0) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL rx0_unexpected: got 0x%0h, expected no donerx", dout0);
            end else checkOutput("rx0_frame", {dout0, perr0, ferr0}, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst && drx1) begin
            if (q1.size() == 0) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL rx1_unexpected: got 0x%0h, expected no donerx", dout1);
            end else checkOutput("rx1_frame", {dout1, perr1, ferr1}, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst && drx2) begin
            if (q2.size() == 0) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL rx2_unexpected: got 0x%0h, expected no donerx", dout2);
            end else checkOutput("rx2_frame", {dout2, perr2, ferr2}, q2.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] seq1;
        int busyErr, doneCnt, busyCnt;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx0, 1);
        checkOutput("reset_txbusy", busy0, 0);
        checkOutput("reset_donetx", dtx0, 0);
        checkOutput("reset_donerx", drx0, 0);
        checkOutput("reset_doutrx", dout0, 0);
        checkOutput("reset_perr", perr0, 0);
        checkOutput("reset_ferr", ferr0, 0);
        checkOutput("reset_tx2", {tx2, busy2, dtx2}, 3'b100);
        rst = 1'b1;
        @(negedge clk);

        loop0 = 1'b1;
        sendTx0(8'h00, 1'b0, 1'b1);
        sendTx0(8'hFF, 1'b0, 1'b1);
        sendTx0(8'hAA, 1'b0, 1'b1);
        sendTx0(8'h55, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("loopback_q_empty", q0.size(), 0);

        // 7E2 frame of 0x5A: start, LSB-first data, even parity 0, two stops
        seq1 = 11'b11010110100;
        q1.push_back({2'b00, 7'h5A, 2'b00});
        busyErr = 0;
        din1 = 7'h5A;
        newd1 = 1'b1;
        @(posedge clk);
        #1;
        newd1 = 1'b0;
        for (int k = 0; k < 176; k++) begin
            @(negedge clk);
            if (k % 16 == 8) checkOutput($sformatf("tx1_bit%0d", k / 16), tx1, seq1[k/16]);
            if (busy1 !== 1'b1) busyErr++;
            if (k == 175) checkOutput("donetx1_last", dtx1, 1);
        end
        checkOutput("txbusy1_len", busyErr, 0);
        @(negedge clk);
        checkOutput("txbusy1_fall", busy1, 0);
        repeat (20) @(negedge clk);
        checkOutput("rx1_q_empty", q1.size(), 0);

        sendTx0(8'h3E, 1'b1, 1'b1);
        busyCnt = 0;
        doneCnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy0) busyCnt++;
            if (dtx0) doneCnt++;
        end
        checkOutput("held_newd_no_refire", busyCnt, 0);
        checkOutput("held_newd_one_donetx", doneCnt, 0);

        loop0 = 1'b0;
        rx0 = 1'b1;
        repeat (10) @(negedge clk);

        q0.push_back({1'b0, 8'h81, 2'b01});
        applyStimulus(0, {6'b0, 1'b0, 8'h81, 1'b0}, 10);
        rx0 = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("ferr_reported", q0.size(), 0);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        q0.push_back({1'b0, 8'hC3, 2'b00});
        applyStimulus(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);

        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        q0.push_back({1'b0, 8'h96, 2'b00});
        applyStimulus(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
        rx0 = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rx0_q_empty", q0.size(), 0);

        // 8O1 frames: 0x3C with wrong parity 0, then correct parity 1, then 0x01 with parity 0
        q2.push_back({1'b0, 8'h3C, 2'b10});
        applyStimulus(2, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        q2.push_back({1'b0, 8'h3C, 2'b00});
        applyStimulus(2, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        q2.push_back({1'b0, 8'h01, 2'b00});
        applyStimulus(2, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
        rx2 = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rx2_q_empty", q2.size(), 0);

        loop0 = 1'b1;
        din0 = 8'h0F;
        newd0 = 1'b1;
        @(posedge clk);
        #1;
        newd0 = 1'b0;
        repeat (50) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("abort_tx_high", tx0, 1);
        checkOutput("abort_txbusy_low", busy0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dtx0 || drx0) doneCnt++;
        end
        checkOutput("abort_no_done", doneCnt, 0);
        checkOutput("abort_q_empty", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
